// File: rtl/dec_onehot_seq.sv
// Registered N-to-2^N one-hot step decoder with load/up/down index sequencing.
// Define DEC_ONEHOT_CHK_EN to add the sticky one-hot consistency checker (err).
module dec_onehot_seq #(
  parameter int SEL_W   = 3,
  parameter int RST_IDX = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [SEL_W-1:0]   sel_in,
  input  logic [SEL_W-1:0]   last,
  output logic [2**SEL_W-1:0] y,
  output logic [SEL_W-1:0]   idx,
  output logic               valid,
`ifdef DEC_ONEHOT_CHK_EN
  output logic               err,
`endif
  output logic               wrap
);

  localparam int OUT_W = 2**SEL_W;

  localparam logic [1:0] M_HOLD = 2'b00;
  localparam logic [1:0] M_LOAD = 2'b01;
  localparam logic [1:0] M_UP   = 2'b10;
  localparam logic [1:0] M_DOWN = 2'b11;

  localparam logic [SEL_W-1:0] IDX_RST = SEL_W'(RST_IDX);
  localparam logic [SEL_W-1:0] IDX_ONE = SEL_W'(1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [SEL_W-1:0] idx_n;
  logic [OUT_W-1:0] y_n;
  logic             wrap_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= IDX_RST;
      y     <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      y     <= y_n;
      wrap  <= wrap_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    wrap_n  = 1'b0;
    if (clr) begin
      state_n = IDLE;
      idx_n   = IDX_RST;
    end else if (en) begin
      unique case (mode)
        M_HOLD: ;
        M_LOAD: begin
          idx_n   = sel_in;
          state_n = ACTIVE;
        end
        M_UP: begin
          state_n = ACTIVE;
          if (state == IDLE) begin
            idx_n = '0;
          end else if (idx >= last) begin
            idx_n  = '0;
            wrap_n = 1'b1;
          end else begin
            idx_n = idx + IDX_ONE;
          end
        end
        M_DOWN: begin
          state_n = ACTIVE;
          if (state == IDLE) begin
            idx_n = last;
          end else if (idx == '0 || idx > last) begin
            idx_n  = last;
            wrap_n = 1'b1;
          end else begin
            idx_n = idx - IDX_ONE;
          end
        end
        default: ;
      endcase
    end
    // decode from next-state values so y lines up with idx/valid
    y_n = (state_n == ACTIVE) ? (OUT_W'(1) << idx_n) : '0;
  end

  assign valid = (state == ACTIVE);

`ifdef DEC_ONEHOT_CHK_EN
  logic multi_hot;
  logic bad;

  assign multi_hot = (y & (y - OUT_W'(1))) != '0;
  assign bad = multi_hot
             || (valid && (y == '0))
             || (valid && (y != (OUT_W'(1) << idx)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err <= 1'b0;
    else if (clr)
      err <= 1'b0;
    else if (bad)
      err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_dec_onehot_seq.sv
// Scoreboard bench for dec_onehot_seq: directed sequences plus random traffic
// against a behavioural model of the index/valid/wrap rules.
module tb_dec_onehot_seq;

  localparam int SEL_W = 3;
  localparam int OUT_W = 8;
  localparam int NIDX  = 8;

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic             en;
  logic [1:0]       mode;
  logic [SEL_W-1:0] sel_in;
  logic [SEL_W-1:0] last;
  logic [OUT_W-1:0] y;
  logic [SEL_W-1:0] idx;
  logic             valid;
  logic             wrap;
`ifdef DEC_ONEHOT_CHK_EN
  logic             err;
`endif

  dec_onehot_seq #(.SEL_W(SEL_W), .RST_IDX(0)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .en     (en),
    .mode   (mode),
    .sel_in (sel_in),
    .last   (last),
    .y      (y),
    .idx    (idx),
    .valid  (valid),
`ifdef DEC_ONEHOT_CHK_EN
    .err    (err),
`endif
    .wrap   (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [OUT_W-1:0] y;
    logic [SEL_W-1:0] idx;
    logic             valid;
    logic             wrap;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   run    = 0;
  bit   mon_on = 1;

  // behavioural model state
  bit m_active;
  int m_idx;
  bit m_wrap;

  function automatic exp_t model_out();
    exp_t e;
    e.valid = m_active;
    e.idx   = SEL_W'(m_idx);
    e.y     = m_active ? OUT_W'(2 ** m_idx) : '0;
    e.wrap  = m_wrap;
    return e;
  endfunction

  task automatic model_step(input bit r, input bit c, input bit e,
                            input int md, input int s, input int l);
    m_wrap = 0;
    if (!r || c) begin
      m_active = 0;
      m_idx    = 0;
    end else if (e) begin
      if (md == 1) begin
        m_idx    = s;
        m_active = 1;
      end else if (md == 2) begin
        if (!m_active) m_idx = 0;
        else if (m_idx >= l) begin m_idx = 0; m_wrap = 1; end
        else m_idx = (m_idx + 1) % NIDX;
        m_active = 1;
      end else if (md == 3) begin
        if (!m_active) m_idx = l;
        else if (m_idx == 0 || m_idx > l) begin m_idx = l; m_wrap = 1; end
        else m_idx = m_idx - 1;
        m_active = 1;
      end
    end
  endtask

  task automatic step(input bit r, input bit c, input bit e,
                      input int md, input int s, input int l);
    @(negedge clk);
    rst_n  = r;
    clr    = c;
    en     = e;
    mode   = 2'(md);
    sel_in = SEL_W'(s);
    last   = SEL_W'(l);
    model_step(r, c, e, md, s, l);
    exp_q.push_back(model_out());
    run = 1;
  endtask

  task automatic check_now(input string name, input exp_t want);
    exp_t got;
    got = '{y: y, idx: idx, valid: valid, wrap: wrap};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got y=%h idx=%0d valid=%b wrap=%b, want y=%h idx=%0d valid=%b wrap=%b",
               name, got.y, got.idx, got.valid, got.wrap,
               want.y, want.idx, want.valid, want.wrap);
    end
  endtask

  // monitor: one popped expectation per clock edge
  initial begin
    exp_t want;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(posedge clk);
      #1;
      if (run && mon_on) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: got empty queue, want an entry");
        end else begin
          want = exp_q.pop_front();
          check_now("cycle", want);
`ifdef DEC_ONEHOT_CHK_EN
          checks++;
          if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_quiet: got %b want 0", err);
          end
`endif
        end
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    clr    = 1'b0;
    en     = 1'b0;
    mode   = 2'b00;
    sel_in = '0;
    last   = '0;
    m_active = 0;
    m_idx    = 0;
    m_wrap   = 0;
    #1;
    check_now("reset_init", '{y: 8'h00, idx: 3'd0, valid: 1'b0, wrap: 1'b0});

    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // LOAD 6 then hold with en=0
    step(1, 0, 1, 1, 6, 7);
    step(1, 0, 0, 1, 2, 7);
    step(1, 0, 1, 0, 2, 7);

    // UP wrap with last=4 from IDLE
    step(1, 1, 0, 0, 0, 4);
    for (int i = 0; i < 6; i++) step(1, 0, 1, 2, 0, 4);

    // DOWN from IDLE with last=2, then LOAD 7 and DOWN
    step(1, 1, 0, 0, 0, 2);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 3, 0, 2);
    step(1, 0, 1, 1, 7, 2);
    step(1, 0, 1, 3, 0, 2);

    // clr beats en/mode at idx=3
    step(1, 0, 1, 1, 3, 7);
    step(1, 1, 1, 2, 0, 7);
    step(1, 0, 1, 2, 0, 7);

    // last=0 wraps every enabled cycle in both directions
    for (int i = 0; i < 3; i++) step(1, 0, 1, 2, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 3, 0, 0);

    // async reset mid-count at idx=5
    step(1, 0, 1, 1, 5, 7);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_now("async_reset", '{y: 8'h00, idx: 3'd0, valid: 1'b0, wrap: 1'b0});
    step(0, 0, 1, 2, 0, 7);
    step(1, 0, 1, 2, 0, 7);

    // randomized traffic
    begin
      int l;
      l = 5;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 15) == 0) l = $urandom_range(0, NIDX - 1);
        step($urandom_range(0, 99) >= 2,
             $urandom_range(0, 99) < 5,
             $urandom_range(0, 9) < 8,
             $urandom_range(0, 3),
             $urandom_range(0, NIDX - 1),
             l);
      end
    end

`ifdef DEC_ONEHOT_CHK_EN
    step(1, 0, 1, 1, 2, 7);
    @(posedge clk);
    #2;
    mon_on = 0;
    @(negedge clk);
    force dut.y = 8'h03;
    @(negedge clk);
    release dut.y;
    en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b want 1", err);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clr: got %b want 0", err);
    end
`else
    @(posedge clk);
    #3;
`endif

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
